// File: rtl/debounce_multi_if.sv
// debounce_multi_if
//   Button-side bundle for debounce_multi. The conditioner sits on the
//   slave modport. Whoever drives the raw pins and consumes the clean
//   events (for example a testbench or the board top) uses the master modport.
//   Parameters:
//     N_CH    number of button channels
//   Signals (all N_CH wide):
//     i_btn   raw asynchronous button inputs
//     o_btn   debounced level
//     o_rise  one-cycle pulse on each debounced 0->1
//     o_fall  one-cycle pulse on each debounced 1->0
//     o_long  one-cycle long-press pulse (0 unless long-press is compiled in)
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_btn;
    logic [N_CH-1:0] o_btn;
    logic [N_CH-1:0] o_rise;
    logic [N_CH-1:0] o_fall;
    logic [N_CH-1:0] o_long;

    modport master (
        output i_btn,
        input  o_btn,
        input  o_rise,
        input  o_fall,
        input  o_long
    );

    modport slave (
        input  i_btn,
        output o_btn,
        output o_rise,
        output o_fall,
        output o_long
    );
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi
//   Multi-channel push-button conditioner. Each channel has three stages:
//     1. It synchronises its raw input.
//     2. It rejects chatter shorter than STABLE_CNT sampled cycles.
//     3. It produces a registered clean level plus one-cycle rise/fall pulses.
//   If you define DEBOUNCE_LONG_PRESS_EN, the block also adds a per-channel
//   hold counter. That counter emits one o_long pulse when a press has been
//   held for LONG_CNT cycles. Without the macro, o_long is tied to 0.
//   Parameters:
//     N_CH         number of independent channels
//     SYNC_STAGES  synchroniser depth (>= 2)
//     STABLE_CNT   cycles a new level must persist before acceptance (>= 1)
//     LONG_CNT     held-pressed cycles before o_long (macro build only)
//     CNT_W        counter width, must hold max(STABLE_CNT, LONG_CNT)
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    debounce_multi_if.slave (i_btn in; o_btn/o_rise/o_fall/o_long out)
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 1_000_000,
    parameter int LONG_CNT    = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic            clk,
    input  logic            reset,
    debounce_multi_if.slave bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CNT < 1) begin : g_bad_stable
        $error("debounce_multi: STABLE_CNT must be at least 1");
    end
    if (CNT_W < $clog2(STABLE_CNT + 1) || CNT_W < $clog2(LONG_CNT + 1)) begin : g_bad_width
        $error("debounce_multi: CNT_W too narrow for STABLE_CNT/LONG_CNT");
    end

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } state_t;

    // Count value on which the STABLE_CNT-th consecutive mismatch is seen.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    state_t           state_q [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [N_CH-1:0]  btn_q;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  mismatch;
    logic [N_CH-1:0]  commit;

    assign s = sync_q[SYNC_STAGES-1];

    // A channel commits on the edge that samples its STABLE_CNT-th
    // consecutive mismatch. If STABLE_CNT is 1, that is the very first one.
    always_comb begin
        mismatch = s ^ btn_q;
        commit   = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            commit[ch] = mismatch[ch] &&
                         ((STABLE_CNT == 1) ||
                          (state_q[ch] == ST_PENDING && cnt_q[ch] == STABLE_LAST));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= ST_STABLE;
                cnt_q[ch]   <= '0;
            end
            btn_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q[0] <= bus.i_btn;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                if (commit[ch]) begin
                    btn_q[ch]   <= s[ch];
                    rise_q[ch]  <= s[ch];
                    fall_q[ch]  <= ~s[ch];
                    state_q[ch] <= ST_STABLE;
                    cnt_q[ch]   <= '0;
                end else if (mismatch[ch]) begin
                    // STABLE enters PENDING at count 1; PENDING keeps counting.
                    state_q[ch] <= ST_PENDING;
                    cnt_q[ch]   <= cnt_q[ch] + 1'b1;
                end else begin
                    // One sampled agreement restarts the window.
                    state_q[ch] <= ST_STABLE;
                    cnt_q[ch]   <= '0;
                end
            end
        end
    end

    assign bus.o_btn  = btn_q;
    assign bus.o_rise = rise_q;
    assign bus.o_fall = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);

    logic [CNT_W-1:0] hold_q [N_CH];
    logic [N_CH-1:0]  long_q;

    // The hold counter restarts on every commit, rise or fall. It then
    // counts the cycles o_btn stays 1 and saturates at LONG_CNT, so each
    // press yields at most one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                hold_q[ch] <= '0;
            end
            long_q <= '0;
        end else begin
            long_q <= '0;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                if (commit[ch]) begin
                    hold_q[ch] <= '0;
                end else if (btn_q[ch] && hold_q[ch] != LONG_MAX) begin
                    hold_q[ch] <= hold_q[ch] + 1'b1;
                    long_q[ch] <= (hold_q[ch] == LONG_LAST);
                end
            end
        end
    end

    assign bus.o_long = long_q;
`else
    assign bus.o_long = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Directed bench for debounce_multi with these settings: N_CH=2,
//   SYNC_STAGES=2, STABLE_CNT=4, LONG_CNT=20, and a 10 ns clock. Each step
//   does two things. It drives i_btn, and it queues the outputs expected on
//   every following cycle of its window; for each posedge count it holds the
//   level plus pulse vectors. A negedge checker pops the entries and compares
//   them. Latency: an input driven just after a negedge is sampled first on
//   the next edge, and o_btn changes 6 edges later.
module tb_debounce_multi;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] btn;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lng;
        string      tag;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   base;
    int   tests;
    int   failed;
    exp_t sb[$];

    debounce_multi_if #(.N_CH(2)) bus ();

    debounce_multi #(
        .N_CH        (2),
        .SYNC_STAGES (2),
        .STABLE_CNT  (4),
        .LONG_CNT    (20),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic [1:0] obs, input logic [1:0] exp,
                         input string name, input string tag, input int at);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s %s cycle %0d: got %b expected %b", tag, name, at, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            assert (e.cyc == cyc) else begin
                failed++;
                $error("FAIL %s stale entry: got cycle %0d expected cycle %0d", e.tag, cyc, e.cyc);
            end
            check(bus.o_btn,  e.btn,  "o_btn",  e.tag, cyc);
            check(bus.o_rise, e.rise, "o_rise", e.tag, cyc);
            check(bus.o_fall, e.fall, "o_fall", e.tag, cyc);
            check(bus.o_long, e.lng,  "o_long", e.tag, cyc);
        end
    end

    // Queue identical expectations for cycles base+a .. base+b.
    task automatic span(input int a, input int b, input logic [1:0] btn,
                        input logic [1:0] rise, input logic [1:0] fall,
                        input logic [1:0] lng, input string tag);
        for (int k = a; k <= b; k++) begin
            exp_t e;
            e.cyc  = base + k;
            e.btn  = btn;
            e.rise = rise;
            e.fall = fall;
            e.lng  = lng;
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expired expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests  = 0;
        failed = 0;
        base   = 0;

        // Reset held with both buttons pressed, then released.
        reset     = 1'b1;
        bus.i_btn = 2'b11;
        span(1, 3, 2'b00, 2'b00, 2'b00, 2'b00, "in_reset");
        wait_until(2);
        tick();
        reset = 1'b0;
        base  = cyc;
        span(1, 5, 2'b00, 2'b00, 2'b00, 2'b00, "post_reset_wait");
        span(6, 6, 2'b11, 2'b11, 2'b00, 2'b00, "post_reset_rise");
        span(7, 7, 2'b11, 2'b00, 2'b00, 2'b00, "post_reset_hold");
        wait_until(7);

        // Release both buttons together.
        tick();
        base      = cyc;
        bus.i_btn = 2'b00;
        span(1, 5, 2'b11, 2'b00, 2'b00, 2'b00, "release_wait");
        span(6, 6, 2'b00, 2'b00, 2'b11, 2'b00, "release_fall");
        span(7, 7, 2'b00, 2'b00, 2'b00, 2'b00, "release_idle");
        wait_until(7);

        // ch0 chatters for 10 cycles and then holds 1. ch1 stays quiet.
        tick();
        base = cyc;
        span(1, 15, 2'b00, 2'b00, 2'b00, 2'b00, "chatter");
        span(16, 16, 2'b01, 2'b01, 2'b00, 2'b00, "chatter_rise");
        span(17, 17, 2'b01, 2'b00, 2'b00, 2'b00, "chatter_hold");
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            bus.i_btn = {1'b0, (k % 2) == 0};
        end
        tick();
        bus.i_btn = 2'b01;
        wait_until(17);

        // ch1 glitches high for 3 cycles, which is shorter than the window.
        tick();
        base      = cyc;
        bus.i_btn = 2'b11;
        span(1, 8, 2'b01, 2'b00, 2'b00, 2'b00, "glitch");
        tick();
        tick();
        tick();
        bus.i_btn = 2'b01;
        wait_until(8);

        // ch0 releases while ch1 is pressed in the same cycle.
        tick();
        base      = cyc;
        bus.i_btn = 2'b10;
        span(1, 5, 2'b01, 2'b00, 2'b00, 2'b00, "swap_wait");
        span(6, 6, 2'b10, 2'b10, 2'b01, 2'b00, "swap_edge");
        span(7, 7, 2'b10, 2'b00, 2'b00, 2'b00, "swap_hold");
        wait_until(7);

        // ch0 is held for 30 cycles after its rise while ch1 releases.
        tick();
        base      = cyc;
        bus.i_btn = 2'b01;
        span(1, 5, 2'b10, 2'b00, 2'b00, 2'b00, "long_wait");
        span(6, 6, 2'b01, 2'b01, 2'b10, 2'b00, "long_rise");
        span(7, 25, 2'b01, 2'b00, 2'b00, 2'b00, "long_hold");
        span(26, 26, 2'b01, 2'b00, 2'b00, LONG_EN ? 2'b01 : 2'b00, "long_pulse");
        span(27, 36, 2'b01, 2'b00, 2'b00, 2'b00, "long_after");
        wait_until(36);

        tick();
        base      = cyc;
        bus.i_btn = 2'b00;
        span(1, 5, 2'b01, 2'b00, 2'b00, 2'b00, "long_rel_wait");
        span(6, 6, 2'b00, 2'b00, 2'b01, 2'b00, "long_rel_fall");
        span(7, 7, 2'b00, 2'b00, 2'b00, 2'b00, "long_rel_idle");
        wait_until(7);

        // Short press: o_btn stays high for 15 cycles, so no o_long.
        tick();
        base      = cyc;
        bus.i_btn = 2'b01;
        span(1, 5, 2'b00, 2'b00, 2'b00, 2'b00, "short_wait");
        span(6, 6, 2'b01, 2'b01, 2'b00, 2'b00, "short_rise");
        span(7, 20, 2'b01, 2'b00, 2'b00, 2'b00, "short_hold");
        span(21, 21, 2'b00, 2'b00, 2'b01, 2'b00, "short_fall");
        span(22, 30, 2'b00, 2'b00, 2'b00, 2'b00, "short_after");
        wait_until(14);
        tick();
        bus.i_btn = 2'b00;
        wait_until(30);

        // Reset is asserted 2 cycles into a ch0 window, then released with ch0 held.
        tick();
        base      = cyc;
        bus.i_btn = 2'b01;
        span(1, 12, 2'b00, 2'b00, 2'b00, 2'b00, "rst_pending");
        wait_until(3);
        tick();
        reset = 1'b1;
        check(bus.o_btn | bus.o_rise | bus.o_fall | bus.o_long, 2'b00,
              "outputs", "rst_assert", cyc);
        wait_until(6);
        tick();
        reset = 1'b0;
        base  = cyc;
        span(6, 6, 2'b01, 2'b01, 2'b00, 2'b00, "rst_rise");
        span(7, 8, 2'b01, 2'b00, 2'b00, 2'b00, "rst_hold");
        wait_until(8);
        tick();

        tests++;
        assert (sb.size() == 0) else begin
            failed++;
            $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
